// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 32-bit MIPS-style words and streams them into
// instruction memory through a registered write port, one word per accepted request.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              bad_funct,
    output logic [ADDR_W:0]   count,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              xfer, legal, wr, last, restart;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Opcodes match the values the UDC decoder expects, including its lw/sw assignment.
    function automatic logic [31:0] encode(input logic [1:0]  kind,
                                           input logic [5:0]  funct,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [4:0]  rd,
                                           input logic [15:0] imm);
        case (kind)
            2'b00:   return {6'b000000, rs, rt, rd, 5'b00000, funct};
            2'b01:   return {6'b101011, rs, rt, imm};
            2'b10:   return {6'b100011, rs, rt, imm};
            default: return {6'b000100, rs, rt, imm};
        endcase
    endfunction

    assign xfer    = in_valid && in_ready;
    assign legal   = (in_kind != 2'b00) || funct_legal(in_funct);
    assign wr      = xfer && legal;
    assign last    = &ptr;
    assign restart = (state != LOAD) && start;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (finish || (wr && last)) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        done     = (state == DONE);
    end

    // Write stage: the accepted request appears on the memory port one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            bad_funct <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            count     <= '0;
            ptr       <= '0;
        end else begin
            wr_en     <= wr;
            bad_funct <= xfer && !legal;
            if (restart) begin
                ptr   <= '0;
                count <= '0;
            end else if (wr) begin
                wr_addr <= ptr;
                wr_data <= encode(in_kind, in_funct, in_rs, in_rt, in_rd, in_imm);
                count   <= count + (ADDR_W+1)'(1);
                // The session ends on the top word, so the pointer is held rather than wrapped.
                if (!last) ptr <= ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader against a session-level
// reference model (words written so far, active/done flags, expected write port).
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, finish, in_valid;
    logic          in_ready, wr_en, bad_funct, done;
    logic [1:0]    in_kind;
    logic [5:0]    in_funct;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    int          m_active, m_done, m_cnt, exp_wr, exp_bad, exp_addr;
    logic [31:0] exp_data;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bad_funct(bad_funct), .count(count), .done(done)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(input logic [5:0] f);
        logic [5:0] tbl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        foreach (tbl[i]) if (tbl[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [1:0] k, input logic [5:0] fn,
                                             input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [15:0] imm);
        logic [31:0] op [4] = '{32'd0, 32'd43, 32'd35, 32'd4};
        logic [31:0] w;
        w = op[k] * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000;
        if (k == 2'b00) w = w + rd * 32'h800 + fn;
        else            w = w + imm;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input bit v,
                        input logic [1:0] k, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm);
        rst = r; start = s; finish = f; in_valid = v;
        in_kind = k; in_funct = fn; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
        exp_wr = 0; exp_bad = 0;
        if (r) begin
            m_active = 0; m_done = 0; m_cnt = 0; exp_addr = 0; exp_data = '0;
        end else if (m_active != 0) begin
            if (v) begin
                if (k == 2'b00 && !ref_legal(fn)) exp_bad = 1;
                else begin
                    exp_wr = 1; exp_addr = m_cnt; exp_data = ref_word(k, fn, rs, rt, rd, imm);
                    m_cnt++;
                end
            end
            if (f || m_cnt == DEPTH) begin m_active = 0; m_done = 1; end
        end else if (s) begin
            m_active = 1; m_done = 0; m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check("wr_en",     wr_en,     32'(exp_wr));
        check("wr_addr",   wr_addr,   32'(exp_addr));
        check("wr_data",   wr_data,   exp_data);
        check("bad_funct", bad_funct, 32'(exp_bad));
        check("count",     count,     32'(m_cnt));
        check("done",      done,      32'(m_done));
        check("in_ready",  in_ready,  32'(m_active));
    endtask

    task automatic nop(input bit r, input bit s, input bit f);
        step(r, s, f, 1'b0, 2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    endtask

    initial begin
        logic [5:0] fn;
        m_active = 0; m_done = 0; m_cnt = 0; exp_addr = 0; exp_data = '0;

        nop(1, 0, 0);
        nop(1, 0, 0);
        check("reset_ready", in_ready, 32'd0);

        // lw at address 0
        nop(0, 1, 0);
        step(0, 0, 0, 1, 2'b01, 6'h00, 5'd2, 5'd5, 5'd0, 16'h0010);
        check("lw_word", wr_data, 32'hAC450010);

        // sw then add back-to-back
        nop(1, 0, 0);
        nop(0, 1, 0);
        step(0, 0, 0, 1, 2'b10, 6'h00, 5'd2, 5'd5, 5'd0, 16'h0010);
        check("sw_word", wr_data, 32'h8C450010);
        step(0, 0, 0, 1, 2'b00, 6'b100000, 5'd1, 5'd2, 5'd3, 16'h0);
        check("add_word", wr_data, 32'h00221820);
        check("add_addr", wr_addr, 32'd1);

        // beq then illegal funct
        nop(1, 0, 0);
        nop(0, 1, 0);
        step(0, 0, 0, 1, 2'b11, 6'h00, 5'd4, 5'd0, 5'd0, 16'hFFFF);
        check("beq_word", wr_data, 32'h1080FFFF);
        step(0, 0, 0, 1, 2'b00, 6'b000111, 5'd1, 5'd2, 5'd3, 16'h0);
        check("bad_pulse", bad_funct, 32'd1);
        nop(0, 0, 0);
        check("bad_drop", bad_funct, 32'd0);

        // fill all addresses, then restart
        nop(1, 0, 0);
        nop(0, 1, 0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 1, 2'b01, 6'h00, 5'(i), 5'(i + 1), 5'd0, 16'(i * 7));
        check("full_done", done, 32'd1);
        check("full_ready", in_ready, 32'd0);
        step(0, 0, 0, 1, 2'b10, 6'h00, 5'd9, 5'd9, 5'd0, 16'h1234);
        nop(0, 1, 0);
        check("restart_count", count, 32'd0);
        step(0, 0, 0, 1, 2'b11, 6'h00, 5'd3, 5'd7, 5'd0, 16'h00AA);
        check("restart_addr", wr_addr, 32'd0);

        // finish with a legal transfer
        step(0, 0, 1, 1, 2'b00, 6'b101010, 5'd5, 5'd6, 5'd7, 16'h0);
        check("finish_done", done, 32'd1);
        step(0, 0, 0, 1, 2'b01, 6'h00, 5'd1, 5'd1, 5'd0, 16'h0001);

        // reset right after an accepted transfer
        nop(0, 1, 0);
        step(0, 0, 0, 1, 2'b01, 6'h00, 5'd8, 5'd9, 5'd0, 16'hBEEF);
        nop(1, 0, 0);
        check("rst_wr_en", wr_en, 32'd0);
        nop(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            fn = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'b100100;
            if ($urandom_range(0, 3) == 0) fn = 6'b100101;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom), fn, 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoding counterpart of the opcode decoder (UDC): packs instruction fields into 32-bit MIPS-style words, one per accepted request.
- Writes the words sequentially into instruction memory through a registered write port, so test programs are loaded in hardware.
- Uses exactly the opcode and funct values UDC decodes, so every word it emits decodes to the intended control signals.

Parameters:
- ADDR_W, 6, word-address width; instruction memory depth = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a load session at word address 0.
- finish  in  1  ends the load session early.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_kind  in  2  instruction kind: 00 R-type, 01 lw, 10 sw, 11 beq.
- in_funct  in  6  R-type funct field.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field (R-type only).
- in_imm  in  16  immediate field (lw/sw/beq only).
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  encoded instruction word.
- bad_funct  out  1  one-cycle pulse: request rejected for an illegal funct.
- count  out  ADDR_W+1  number of words written in the current session.
- done  out  1  session complete.

Behaviour:
- Reset: state IDLE; wr_en, bad_funct, done and in_ready are 0; wr_addr, wr_data and count are 0; the internal address pointer is 0.
- Reset mid-operation: any pending write is dropped and all state returns to the reset values.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start moves to LOAD; pointer and count are cleared.
  - LOAD: in_ready = 1. A transfer occurs when in_valid && in_ready.
  - LOAD exits to DONE when finish is seen, or when the word at address 2**ADDR_W-1 is written.
  - DONE: done = 1, in_ready = 0, count is held. start returns to LOAD and clears pointer and count.
- start is ignored in LOAD.
- in_valid is ignored outside LOAD.
- Encoding, field order MSB to LSB:
  - R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - lw: {6'b101011, rs, rt, imm}.
  - sw: {6'b100011, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
- Legal R-type funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Latency: a transfer at edge N gives wr_en = 1 for exactly the cycle after edge N, with wr_addr = pointer and wr_data = the encoded word. The pointer and count increment at the same edge. Throughput is one word per cycle.
- Illegal funct on an R-type transfer:
  - no write occurs and the pointer does not increment;
  - bad_funct pulses 1 for the cycle after the edge;
  - the FSM stays in LOAD.
- finish together with a legal transfer: the word is written, then the FSM goes to DONE.
- Last address: a transfer to address 2**ADDR_W-1 writes, count becomes 2**ADDR_W, the FSM enters DONE, and in_ready drops in the same cycle as that wr_en.
- The pointer never wraps inside a session.
- wr_data and wr_addr hold their last values when wr_en = 0.

Test Plan:
- Reset, start, then lw with rs=2, rt=5, imm=0x0010 -> the next cycle shows wr_en=1, wr_addr=0, wr_data=0xAC450010, and count becomes 1.
- sw with rs=2, rt=5, imm=0x0010, followed back-to-back by R-type add with rs=1, rt=2, rd=3, funct=100000 -> consecutive writes 0x8C450010 at address 0 and 0x00221820 at address 1, with no bubble.
- beq with rs=4, rt=0, imm=0xFFFF, then R-type funct=000111 -> 0x1080FFFF is written at address 0; the second request gives bad_funct=1 for one cycle, no write, and count stays 1.
- ADDR_W=2 with in_valid held high -> 4 writes to addresses 0..3, then done=1, in_ready=0 and count=4. A following start restarts at address 0 with count=0.
- finish asserted in the same cycle as a legal transfer -> that word is written, then done=1 and further in_valid is ignored.
- rst asserted in the cycle after an accepted transfer -> no wr_en appears, all outputs return to 0 and the state is IDLE.
